// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the imem loader.
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, load_done, load_err
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data, cpu_hold, load_done, load_err
    );
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream loader: header N, 4*N big-endian data bytes, XOR checksum.
// Writes words to consecutive addresses and holds the CPU until a good load.
module imem_loader #(
    parameter int DEPTH = 64,
    parameter int CNT_W = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_loader_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, DATA, WRITE, CHK, DONE} state_e;

    state_e             state_q, state_d;
    logic               act_q;
    logic [23:0]        word_q, word_d;
    logic [1:0]         bidx_q, bidx_d;
    logic [CNT_W-1:0]   widx_q, widx_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic [7:0]         chk_q, chk_d;
    logic [31:0]        wr_addr_q, wr_addr_d;
    logic [31:0]        wr_data_q, wr_data_d;
    logic               hold_q, hold_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               acc, hdr_ok;

    // act_q keeps in_ready low until the first edge after reset release
    assign bus.in_ready  = act_q & (state_q == IDLE || state_q == DATA || state_q == CHK);
    assign bus.wr_en     = (state_q == WRITE);
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.cpu_hold  = hold_q;
    assign bus.load_done = done_q;
    assign bus.load_err  = err_q;

    assign acc    = bus.in_valid & bus.in_ready;
    assign hdr_ok = (bus.in_data != 8'd0) && ({24'd0, bus.in_data} <= 32'(DEPTH));

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        bidx_d    = bidx_q;
        widx_d    = widx_q;
        n_d       = n_q;
        chk_d     = chk_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        hold_d    = hold_q;
        err_d     = err_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: if (acc) begin
                if (hdr_ok) begin
                    err_d   = 1'b0;
                    hold_d  = 1'b1;
                    n_d     = CNT_W'(bus.in_data);
                    widx_d  = '0;
                    bidx_d  = '0;
                    chk_d   = '0;
                    state_d = DATA;
                end else begin
                    err_d = 1'b1;
                end
            end
            DATA: if (acc) begin
                word_d = {word_q[15:0], bus.in_data};
                chk_d  = chk_q ^ bus.in_data;
                bidx_d = bidx_q + 2'd1;
                if (bidx_q == 2'd3) begin
                    // latch the write now so addr/data stay stable after the strobe
                    wr_data_d = {word_q, bus.in_data};
                    wr_addr_d = {{(30-CNT_W){1'b0}}, widx_q, 2'b00};
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                widx_d  = widx_q + CNT_W'(1);
                state_d = (widx_d == n_q) ? CHK : DATA;
            end
            CHK: if (acc) begin
                if (bus.in_data == chk_q) begin
                    state_d = DONE;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                hold_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            act_q     <= 1'b0;
            word_q    <= '0;
            bidx_q    <= '0;
            widx_q    <= '0;
            n_q       <= '0;
            chk_q     <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            hold_q    <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            act_q     <= 1'b1;
            word_q    <= word_d;
            bidx_q    <= bidx_d;
            widx_q    <= widx_d;
            n_q       <= n_d;
            chk_q     <= chk_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            hold_q    <= hold_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frame table, timing sequences,
// and random frames predicted by a frame-level model.
module tb_imem_loader;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    imem_loader_if bus();

    imem_loader #(.DEPTH(DEPTH), .CNT_W(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]       hdr;
        int               nw;
        logic [2:0][31:0] w;
        logic [7:0]       ck;
        int               exp_wr;
        bit               exp_done;
        bit               exp_err;
        bit               exp_hold;
    } vec_t;

    int n_chk = 0;
    int n_pass = 0;
    int gap_max = 0;
    bit m_hold = 1'b1;
    logic [31:0] mem_m [DEPTH];

    // observed memory side: every write strobe and done pulse
    logic [31:0] wa_log [$];
    logic [31:0] wd_log [$];
    logic [31:0] imem [DEPTH];
    int done_cnt = 0;
    int viol_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wr_en) begin
                wa_log.push_back(bus.wr_addr);
                wd_log.push_back(bus.wr_data);
                if (bus.wr_addr < 32'(DEPTH * 4)) imem[bus.wr_addr[7:2]] <= bus.wr_data;
                if (bus.in_ready || bus.load_done) viol_cnt <= viol_cnt + 1;
            end
            if (bus.load_done) done_cnt <= done_cnt + 1;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    // called and returns at posedge+1
    task automatic send_byte(input logic [7:0] b);
        int  gap;
        bit  hs;
        bit  done;
        gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        repeat (gap) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        done = 1'b0;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            hs = bus.in_ready;
            @(posedge clk); #1;
            if (hs) done = 1'b1;
        end
        if (!done) check("handshake timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
    endtask

    task automatic do_frame(input string nm, input logic [7:0] hdr, input logic [31:0] w [$],
                            input logic [7:0] ck, input int exp_wr, input bit exp_done,
                            input bit exp_err, input bit exp_hold);
        int base;
        int d0;
        base = wa_log.size();
        d0   = done_cnt;
        send_byte(hdr);
        foreach (w[i]) for (int j = 3; j >= 0; j--) send_byte(w[i][8*j +: 8]);
        if (w.size() > 0) send_byte(ck);
        repeat (3) @(posedge clk);
        #1;
        check({nm, " writes"}, 32'(wa_log.size() - base), 32'(exp_wr));
        for (int i = 0; i < exp_wr && i < w.size() && base + i < wa_log.size(); i++) begin
            check($sformatf("%s addr%0d", nm, i), wa_log[base+i], 32'(i * 4));
            check($sformatf("%s data%0d", nm, i), wd_log[base+i], w[i]);
        end
        for (int i = 0; i < exp_wr && i < w.size(); i++) mem_m[i] = w[i];
        check({nm, " done"}, 32'(done_cnt - d0), 32'(exp_done));
        check({nm, " err"}, 32'(bus.load_err), 32'(exp_err));
        check({nm, " hold"}, 32'(bus.cpu_hold), 32'(exp_hold));
        check({nm, " ready"}, 32'(bus.in_ready), 32'd1);
        m_hold = exp_hold;
    endtask

    function automatic vec_t mkv(logic [7:0] hdr, int nw, logic [31:0] a, logic [31:0] b,
                                 logic [31:0] c, logic [7:0] ck, int wr, bit dn, bit er, bit hd);
        mkv.hdr = hdr; mkv.nw = nw; mkv.w = {c, b, a}; mkv.ck = ck;
        mkv.exp_wr = wr; mkv.exp_done = dn; mkv.exp_err = er; mkv.exp_hold = hd;
    endfunction

    initial begin
        vec_t        tv [8];
        logic [31:0] q [$];
        logic [7:0]  ck;
        int          n;
        int          kind;
        bit          ok;
        bit          bad;

        tv[0] = mkv(8'h01, 1, 32'h20020005, 0, 0, 8'h27, 1, 1, 0, 0);
        tv[1] = mkv(8'h03, 3, 32'h20020005, 32'h20070003, 32'h2003000c, 8'h2c, 3, 1, 0, 0);
        tv[2] = mkv(8'h01, 1, 32'h20020005, 0, 0, 8'h00, 1, 0, 1, 1);
        tv[3] = mkv(8'hff, 0, 0, 0, 0, 8'h00, 0, 0, 1, 1);
        tv[4] = mkv(8'h01, 1, 32'h20020005, 0, 0, 8'h27, 1, 1, 0, 0);
        tv[5] = mkv(8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 1, 0);
        tv[6] = mkv(8'h41, 0, 0, 0, 0, 8'h00, 0, 0, 1, 0);
        tv[7] = mkv(8'h02, 2, 32'h11223344, 32'ha0b0c0d0, 0, 8'h44, 2, 1, 0, 0);

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst hold", 32'(bus.cpu_hold), 32'd1);
        check("rst ready", 32'(bus.in_ready), 32'd0);
        check("rst wr_en", 32'(bus.wr_en), 32'd0);
        check("rst done", 32'(bus.load_done), 32'd0);
        check("rst err", 32'(bus.load_err), 32'd0);
        check("rst wr_addr", bus.wr_addr, 32'd0);
        check("rst wr_data", bus.wr_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel ready pre-edge", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rel ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;

        // write latency and completion timing, single word
        send_byte(8'h01);
        send_byte(8'h20); send_byte(8'h02); send_byte(8'h00); send_byte(8'h05);
        @(negedge clk);
        check("lat wr_en", 32'(bus.wr_en), 32'd1);
        check("lat ready", 32'(bus.in_ready), 32'd0);
        check("lat addr", bus.wr_addr, 32'h0);
        check("lat data", bus.wr_data, 32'h20020005);
        @(negedge clk);
        check("lat wr_en off", 32'(bus.wr_en), 32'd0);
        check("lat data held", bus.wr_data, 32'h20020005);
        @(posedge clk); #1;
        send_byte(8'h27);
        @(negedge clk);
        check("m+0 done", 32'(bus.load_done), 32'd0);
        check("m+0 hold", 32'(bus.cpu_hold), 32'd1);
        @(negedge clk);
        check("m+1 done", 32'(bus.load_done), 32'd1);
        check("m+1 hold", 32'(bus.cpu_hold), 32'd0);
        @(negedge clk);
        check("m+2 done", 32'(bus.load_done), 32'd0);
        check("m+2 err", 32'(bus.load_err), 32'd0);
        @(posedge clk); #1;
        mem_m[0] = 32'h20020005;
        m_hold = 1'b0;

        // directed frame table with random valid gaps
        gap_max = 2;
        foreach (tv[k]) begin
            q.delete();
            for (int i = 0; i < tv[k].nw; i++) q.push_back(tv[k].w[i]);
            do_frame($sformatf("vec%0d", k), tv[k].hdr, q, tv[k].ck, tv[k].exp_wr,
                     tv[k].exp_done, tv[k].exp_err, tv[k].exp_hold);
        end

        // bad header and mismatch timing
        gap_max = 0;
        send_byte(8'h00);
        @(negedge clk);
        check("badhdr err", 32'(bus.load_err), 32'd1);
        check("badhdr ready", 32'(bus.in_ready), 32'd1);
        check("badhdr hold", 32'(bus.cpu_hold), 32'd0);
        @(posedge clk); #1;
        send_byte(8'h01);
        send_byte(8'h20); send_byte(8'h02); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h99);
        @(negedge clk);
        check("mism err", 32'(bus.load_err), 32'd1);
        check("mism ready", 32'(bus.in_ready), 32'd1);
        check("mism hold", 32'(bus.cpu_hold), 32'd1);
        @(posedge clk); #1;

        // reset in the middle of a word
        n = wa_log.size();
        send_byte(8'h02); send_byte(8'haa); send_byte(8'hbb);
        #2 rst_n = 1'b0;
        #1;
        check("midrst hold", 32'(bus.cpu_hold), 32'd1);
        check("midrst ready", 32'(bus.in_ready), 32'd0);
        check("midrst err", 32'(bus.load_err), 32'd0);
        check("midrst wr_data", bus.wr_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst no write", 32'(wa_log.size() - n), 32'd0);
        q.delete(); q.push_back(32'h20070003);
        do_frame("reload", 8'h01, q, 8'h24, 1, 1, 0, 0);

        // random frames against the frame-level model
        for (int r = 0; r < 16; r++) begin
            gap_max = $urandom_range(0, 3);
            kind = $urandom_range(0, 9);
            if (r == 0) n = DEPTH;
            else if (kind < 2) n = ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(DEPTH + 1, 255));
            else n = $urandom_range(1, 6);
            ok  = (n >= 1 && n <= DEPTH);
            bad = (kind >= 2 && kind < 4);
            q.delete();
            ck = 8'h00;
            if (ok) for (int i = 0; i < n; i++) begin
                q.push_back($urandom);
                ck = ck ^ q[i][31:24] ^ q[i][23:16] ^ q[i][15:8] ^ q[i][7:0];
            end
            if (bad) ck = ck ^ 8'($urandom_range(1, 255));
            if (!ok) do_frame($sformatf("rnd%0d", r), 8'(n), q, ck, 0, 0, 1, m_hold);
            else     do_frame($sformatf("rnd%0d", r), 8'(n), q, ck, n, !bad, bad, bad);
        end

        for (int i = 0; i < DEPTH; i++) check($sformatf("imem[%0d]", i), imem[i], mem_m[i]);
        check("wr_en overlap", 32'(viol_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream programmer for the writable instruction memory. It accepts a framed byte stream (word count, big-endian instruction words, XOR checksum) over a valid/ready handshake. It assembles 32-bit words and issues one write per word at consecutive word-aligned addresses starting at 0. It holds the processor (`cpu_hold`) until the memory contents have been validated by a successful load.

## Interface
- `DEPTH`, 64: instruction memory depth in words; legal word counts are 1..DEPTH.
- `CNT_W`, 7: width of the internal word counter; must hold DEPTH.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  byte available on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader can accept a byte; a transfer occurs on a rising edge with `in_valid & in_ready`.
- `wr_en`  out  1  one-cycle instruction memory write strobe.
- `wr_addr`  out  32  byte address of the write, word-aligned (`[1:0]=0`), zero-extended.
- `wr_data`  out  32  instruction word to write.
- `cpu_hold`  out  1  processor must stall/hold PC while high.
- `load_done`  out  1  one-cycle pulse on a successful load.
- `load_err`  out  1  sticky error flag.

## Operation
- Frame format: header byte N, then 4·N data bytes, then 1 checksum byte.
  - Within each word, the first byte maps to `[31:24]` and the last to `[7:0]`.
  - Checksum = XOR of all 4·N data bytes; the header is excluded.
- States: IDLE, DATA, WRITE, CHK, DONE.
- IDLE, `in_ready=1`. On an accepted header byte:
  - N in 1..DEPTH: clear `load_err`, set `cpu_hold`, zero the word index, byte index and checksum accumulator, go to DATA.
  - N = 0 or N > DEPTH: set `load_err`, leave `cpu_hold` unchanged, stay in IDLE.
- DATA, `in_ready=1`.
  - Each accepted byte shifts into the word register and is XORed into the checksum.
  - The 4th byte goes to WRITE.
- WRITE, `in_ready=0`.
  - `wr_en=1` for exactly one cycle, with `wr_addr = index·4` and `wr_data` = assembled word.
  - Increment the index.
  - If the index reaches N, go to CHK; otherwise go to DATA.
- CHK, `in_ready=1`. On an accepted byte:
  - Equal to the accumulator: go to DONE.
  - Not equal: set `load_err` and go to IDLE. `cpu_hold` stays 1; already-written words remain in memory.
- DONE, `in_ready=0`: `load_done=1` for one cycle, `cpu_hold` cleared, go to IDLE.
- `wr_addr` and `wr_data` hold their last values when `wr_en=0`.
- `cpu_hold` is set only by a valid header and cleared only by DONE.

## Timing
- Reset values (while `rst_n` is low, asynchronously):
  - State IDLE.
  - `in_ready=0`, `wr_en=0`, `wr_addr=0`, `wr_data=0`.
  - `cpu_hold=1`: memory is unvalidated after reset.
  - `load_done=0`, `load_err=0`.
- After reset: `in_ready=1` in the first cycle after `rst_n` rises.
- Write latency: 4th byte accepted at edge k → `wr_en` high in the cycle following edge k; the next byte can be accepted no earlier than edge k+2.
- Throughput: 5 cycles per word minimum.
- Completion: checksum accepted at edge m → `load_done` high between edges m+1 and m+2 → `cpu_hold` low after edge m+1.
- Checksum mismatch: `load_err` high after edge m; back in IDLE with `in_ready=1`.
- Bad header accepted at edge h: `load_err` high after edge h; `in_ready` stays 1.
- `in_valid` may drop at any point; state and partial word are held indefinitely.
- `in_data` is ignored whenever `in_ready=0`.
- Reset mid-load: immediate return to reset values; partial words are discarded and no write is issued. Previously written words are not erased.

## Test plan
- Reset: hold `rst_n` low → `cpu_hold=1`, `in_ready=0`, `wr_en=0`, `load_done=0`, `load_err=0`. Release → `in_ready=1` next cycle.
- Single word: bytes 01, 20,02,00,05, 27 → one `wr_en` with `wr_addr=0x0`, `wr_data=0x20020005`; `load_done` pulses once; `cpu_hold=0`; `load_err=0`.
- Three words with random `in_valid` gaps: header 03, words 20020005, 20070003, 2003000c, checksum 2c.
  - Writes at 0x0/0x4/0x8 with matching data.
  - `in_ready=0` during each WRITE cycle; no byte lost or duplicated.
- Bad checksum: bytes 01, 20,02,00,05, 00 → write still occurs; `load_err=1`; `load_done` never pulses; `cpu_hold=1`. A following good single-word load clears `load_err` at its header and ends with `cpu_hold=0`.
- Bad headers: 00, then 41 (DEPTH=64) → no `wr_en`; `load_err=1`; `cpu_hold` unchanged; the next valid frame loads correctly.
- Reset mid-load: header 02 plus 2 data bytes, then pulse `rst_n` → reset values, no write. A new frame 01, 20,07,00,03, 24 writes 0x20070003 at address 0x0.
